// File: rtl/srrc_sym_fir_param_flt.sv
// Parametrised odd-length symmetric FIR for the SRRC receive path: pre-add, multiply,
// registered adder tree, round/saturate, with a double-buffered run-time coefficient bank.
module srrc_sym_fir_param_flt #(
  parameter int NUM_TAPS  = 189,
  parameter int DATA_W    = 18,
  parameter int COEF_W    = 18,
  parameter int OUT_SHIFT = 17
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    sam_clk_en,
  input  logic signed [DATA_W-1:0]                in,
  input  logic                                    bypass,
  input  logic                                    coef_wr_en,
  input  logic [$clog2((NUM_TAPS+1)/2)-1:0]       coef_addr,
  input  logic signed [COEF_W-1:0]                coef_wr_data,
  input  logic                                    coef_swap,
  output logic                                    swap_pending,
  output logic signed [DATA_W-1:0]                out,
  output logic                                    out_valid,
  output logic                                    sat
);

  localparam int NUM_HALF = (NUM_TAPS + 32'sd1) / 32'sd2;
  localparam int TREE_D   = $clog2(NUM_HALF);
  localparam int ACC_W    = DATA_W + 32'sd1 + COEF_W + TREE_D;
  localparam int ADDR_W   = $clog2(NUM_HALF);
  localparam int SIDE     = TREE_D + 32'sd2;

  function automatic int lvl_cnt(input int lvl);
    int n;
    n = NUM_HALF;
    for (int i = 32'sd0; i < lvl; i++) n = (n + 32'sd1) / 32'sd2;
    return n;
  endfunction

  function automatic int lvl_off(input int lvl);
    int o;
    o = 32'sd0;
    for (int i = 32'sd0; i < lvl; i++) o = o + lvl_cnt(i);
    return o;
  endfunction

  localparam int NODES = lvl_off(TREE_D + 32'sd1);
  localparam logic [ADDR_W:0]         NUM_HALF_W = (ADDR_W + 1)'(NUM_HALF);
  localparam logic signed [ACC_W:0]   RND        = ({{ACC_W{1'b0}}, 1'b1} << OUT_SHIFT) >> 1;
  localparam logic signed [ACC_W:0]   OUT_MAX    = {{(ACC_W + 1 - DATA_W){1'b0}}, 1'b0, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0]   OUT_MIN    = {{(ACC_W + 2 - DATA_W){1'b1}}, {(DATA_W - 1){1'b0}}};
  localparam logic signed [DATA_W-1:0] MAX_D     = {1'b0, {(DATA_W - 1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_D     = {1'b1, {(DATA_W - 1){1'b0}}};

  logic signed [DATA_W-1:0] x_r      [NUM_TAPS];
  logic                     vld_x_r;
  logic signed [COEF_W-1:0] shadow_r [NUM_HALF];
  logic signed [COEF_W-1:0] shadow_s [NUM_HALF];
  logic signed [COEF_W-1:0] active_r [NUM_HALF];
  logic signed [COEF_W-1:0] coef_p_r [NUM_HALF];
  logic signed [DATA_W:0]   p_r      [NUM_HALF];
  logic signed [ACC_W-1:0]  node_r   [NODES];
  logic [SIDE-1:0]          vld_r;
  logic [SIDE-1:0]          byp_r;
  logic signed [DATA_W-1:0] ctr_r    [SIDE];
  logic                     swap_req_s;
  logic signed [ACC_W:0]    rsum_s;
  logic signed [ACC_W:0]    shf_s;

  assign swap_req_s = swap_pending | coef_swap;

  // Shadow bank with this cycle's write merged in, so a same-cycle swap picks it up.
  always_comb begin
    shadow_s = shadow_r;
    if (coef_wr_en && ({1'b0, coef_addr} < NUM_HALF_W)) begin
      shadow_s[coef_addr] = coef_wr_data;
    end else begin
      shadow_s = shadow_r;
    end
  end

  // Delay line, coefficient banks and swap handshake.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 32'sd0; i < NUM_TAPS; i++) x_r[i] <= '0;
      for (int k = 32'sd0; k < NUM_HALF; k++) begin
        shadow_r[k] <= '0;
        active_r[k] <= '0;
      end
      vld_x_r      <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      vld_x_r <= sam_clk_en;
      if (sam_clk_en) begin
        x_r[0] <= in;
        for (int i = 32'sd1; i < NUM_TAPS; i++) x_r[i] <= x_r[i-1];
      end
      shadow_r <= shadow_s;
      if (sam_clk_en && swap_req_s) begin
        active_r     <= shadow_s;
        swap_pending <= 1'b0;
      end else begin
        swap_pending <= swap_req_s;
      end
    end
  end

  // Pre-add; the coefficients are captured alongside so a later swap cannot reach this sample.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 32'sd0; k < NUM_HALF; k++) begin
        p_r[k]      <= '0;
        coef_p_r[k] <= '0;
      end
    end else begin
      for (int k = 32'sd0; k < NUM_HALF - 1; k++)
        p_r[k] <= (DATA_W + 1)'(x_r[k]) + (DATA_W + 1)'(x_r[NUM_TAPS - 1 - k]);
      p_r[NUM_HALF-1] <= (DATA_W + 1)'(x_r[NUM_HALF-1]);
      coef_p_r        <= active_r;
    end
  end

  // Products land directly in tree level 0, sign-extended to the accumulator width.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 32'sd0; k < NUM_HALF; k++) node_r[k] <= '0;
    end else begin
      for (int k = 32'sd0; k < NUM_HALF; k++)
        node_r[k] <= ACC_W'(p_r[k]) * ACC_W'(coef_p_r[k]);
    end
  end

  for (genvar j = 1; j <= TREE_D; j++) begin : g_lvl
    localparam int N_IN    = lvl_cnt(j - 1);
    localparam int N_OUT   = lvl_cnt(j);
    localparam int OFF_IN  = lvl_off(j - 1);
    localparam int OFF_OUT = lvl_off(j);
    for (genvar i = 0; i < N_OUT; i++) begin : g_node
      if (32'sd2 * i + 32'sd1 < N_IN) begin : g_add
        always_ff @(posedge clk) begin
          if (!reset) node_r[OFF_OUT+i] <= '0;
          else        node_r[OFF_OUT+i] <= node_r[OFF_IN+2*i] + node_r[OFF_IN+2*i+1];
        end
      end else begin : g_pass
        always_ff @(posedge clk) begin
          if (!reset) node_r[OFF_OUT+i] <= '0;
          else        node_r[OFF_OUT+i] <= node_r[OFF_IN+2*i];
        end
      end
    end
  end

  // Valid, bypass flag and centre sample travel beside the arithmetic.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_r <= '0;
      byp_r <= '0;
      for (int s = 32'sd0; s < SIDE; s++) ctr_r[s] <= '0;
    end else begin
      vld_r    <= {vld_r[SIDE-2:0], vld_x_r};
      byp_r    <= {byp_r[SIDE-2:0], bypass};
      ctr_r[0] <= x_r[NUM_HALF-1];
      for (int s = 32'sd1; s < SIDE; s++) ctr_r[s] <= ctr_r[s-1];
    end
  end

  // Round half up, then arithmetic shift.
  always_comb begin
    rsum_s = (ACC_W + 1)'(node_r[NODES-1]) + RND;
    shf_s  = rsum_s >>> OUT_SHIFT;
  end

  // Output stage: bypass, saturate or pass the rounded value; out holds between strobes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out       <= '0;
      out_valid <= 1'b0;
      sat       <= 1'b0;
    end else begin
      out_valid <= vld_r[SIDE-1];
      sat       <= 1'b0;
      if (vld_r[SIDE-1]) begin
        if (byp_r[SIDE-1]) begin
          out <= ctr_r[SIDE-1];
        end else if (shf_s > OUT_MAX) begin
          out <= MAX_D;
          sat <= 1'b1;
        end else if (shf_s < OUT_MIN) begin
          out <= MIN_D;
          sat <= 1'b1;
        end else begin
          out <= shf_s[DATA_W-1:0];
        end
      end else begin
        out <= out;
      end
    end
  end

endmodule

// File: tb/tb_srrc_sym_fir_param_flt.sv
// Directed bench: default-size filter plus two 7-tap instances (OUT_SHIFT 0 and 1) sharing stimulus.
module tb_srrc_sym_fir_param_flt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default instance
  logic               a_reset, a_en, a_byp, a_wr, a_swap;
  logic signed [17:0] a_in, a_data;
  logic [6:0]         a_addr;
  logic               a_pend, a_ov, a_sat;
  logic signed [17:0] a_out;

  // Shared stimulus for the two 7-tap instances
  logic               s_reset, s_en, s_byp, s_wr, s_swap;
  logic signed [17:0] s_in, s_data;
  logic [1:0]         s_addr;
  logic               b_pend, b_ov, b_sat, c_pend, c_ov, c_sat;
  logic signed [17:0] b_out, c_out;

  srrc_sym_fir_param_flt dut_a (
    .clk(clk), .reset(a_reset), .sam_clk_en(a_en), .in(a_in), .bypass(a_byp),
    .coef_wr_en(a_wr), .coef_addr(a_addr), .coef_wr_data(a_data), .coef_swap(a_swap),
    .swap_pending(a_pend), .out(a_out), .out_valid(a_ov), .sat(a_sat)
  );

  srrc_sym_fir_param_flt #(.NUM_TAPS(7), .OUT_SHIFT(0)) dut_b (
    .clk(clk), .reset(s_reset), .sam_clk_en(s_en), .in(s_in), .bypass(s_byp),
    .coef_wr_en(s_wr), .coef_addr(s_addr), .coef_wr_data(s_data), .coef_swap(s_swap),
    .swap_pending(b_pend), .out(b_out), .out_valid(b_ov), .sat(b_sat)
  );

  srrc_sym_fir_param_flt #(.NUM_TAPS(7), .OUT_SHIFT(1)) dut_c (
    .clk(clk), .reset(s_reset), .sam_clk_en(s_en), .in(s_in), .bypass(s_byp),
    .coef_wr_en(s_wr), .coef_addr(s_addr), .coef_wr_data(s_data), .coef_swap(s_swap),
    .swap_pending(c_pend), .out(c_out), .out_valid(c_ov), .sat(c_sat)
  );

  task automatic check_val(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_b(input int c0, input int c1, input int c2, input int c3);
    int cv [4];
    cv = '{c0, c1, c2, c3};
    s_wr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_addr = k[1:0];
      s_data = 18'(cv[k]);
      tick();
    end
    s_wr   = 1'b0;
    s_swap = 1'b1;
    tick();
    s_swap = 1'b0;
  endtask

  initial begin
    int lat, idx, n, sidx, expv;
    int q [$];
    logic pend_m, swapped_m, req;

    a_reset = 1'b0; a_en = 1'b0; a_byp = 1'b0; a_wr = 1'b0; a_swap = 1'b0;
    a_in = '0; a_data = '0; a_addr = '0;
    s_reset = 1'b0; s_en = 1'b0; s_byp = 1'b0; s_wr = 1'b0; s_swap = 1'b0;
    s_in = '0; s_data = '0; s_addr = '0;
    repeat (3) tick();
    check_val("rst_a_out", a_out, 0);
    check_val("rst_a_valid", a_ov, 0);
    check_val("rst_a_sat", a_sat, 0);
    check_val("rst_a_pend", a_pend, 0);
    check_val("rst_b_valid", b_ov, 0);
    a_reset = 1'b1;
    s_reset = 1'b1;
    tick();

    // Full-scale coefficients, saturating both ways
    a_wr = 1'b1;
    a_data = 18'sd131071;
    for (int k = 0; k < 95; k++) begin
      a_addr = k[6:0];
      tick();
    end
    a_wr = 1'b0;
    a_swap = 1'b1;
    tick();
    a_swap = 1'b0;
    check_val("a_pend_set", a_pend, 1);
    tick();
    check_val("a_pend_hold", a_pend, 1);
    a_in = 18'sd131071;
    a_en = 1'b1;
    tick();
    check_val("a_pend_clr", a_pend, 0);
    repeat (210) tick();
    check_val("a_pos_valid", a_ov, 1);
    check_val("a_pos_out", a_out, 131071);
    check_val("a_pos_sat", a_sat, 1);
    a_in = -18'sd131072;
    repeat (210) tick();
    check_val("a_neg_out", a_out, -131072);
    check_val("a_neg_sat", a_sat, 1);

    // Reset mid-stream
    a_reset = 1'b0;
    tick();
    check_val("a_mid_valid", a_ov, 0);
    check_val("a_mid_out", a_out, 0);
    check_val("a_mid_sat", a_sat, 0);
    a_reset = 1'b1;
    a_en = 1'b0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (a_ov) n++;
    end
    check_val("a_flush", n, 0);

    // Zero bank after reset, latency of the first output
    a_in = 18'sd5000;
    a_en = 1'b1;
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 20) a_en = 1'b0;
      if (a_ov && lat == 0) lat = k;
      if (a_ov) check_val("a_zero_out", a_out, 0);
    end
    check_val("a_latency", lat, 11);

    // 7-tap impulse response
    load_b(1000, 2000, 3000, 4000);
    check_val("b_pend_set", b_pend, 1);
    s_in = 18'sd1;
    s_en = 1'b1;
    idx = 0;
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e == 1) check_val("b_pend_clr", b_pend, 0);
      if (b_ov) begin
        expv = (idx < 4) ? 1000 * (idx + 1) : (idx < 7) ? 1000 * (7 - idx) : 0;
        check_val("imp_lat", e, idx + 6);
        check_val("imp_val", b_out, expv);
        idx++;
      end
      s_in = '0;
      s_en = (e < 8);
    end
    check_val("imp_count", idx, 8);

    // Rounding with centre coefficient 1
    load_b(0, 0, 0, 1);
    s_in = 18'sd3;
    s_en = 1'b1;
    repeat (12) tick();
    check_val("rnd_p_valid", c_ov, 1);
    check_val("rnd_p_c", c_out, 2);
    check_val("rnd_p_b", b_out, 3);
    check_val("rnd_p_sat", c_sat, 0);
    s_in = -18'sd3;
    repeat (12) tick();
    check_val("rnd_n_c", c_out, -1);
    check_val("rnd_n_b", b_out, -3);

    // Swap atomicity with sparse enables; last write shares the cycle with the swap
    load_b(1, 1, 1, 1);
    s_in = 18'sd1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      s_en = (cyc % 4 == 0);
      tick();
    end
    s_en = 1'b0;
    s_wr = 1'b1;
    s_data = 18'sd10;
    for (int k = 0; k < 3; k++) begin
      s_addr = k[1:0];
      tick();
    end
    s_wr = 1'b0;
    repeat (10) tick();
    pend_m = 1'b0;
    swapped_m = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      s_en   = (cyc % 4 == 0) && (cyc < 28);
      s_swap = (cyc == 10);
      s_wr   = (cyc == 10);
      s_addr = 2'd3;
      s_data = 18'sd10;
      req = pend_m || s_swap;
      if (s_en) q.push_back((swapped_m || req) ? 70 : 7);
      if (s_en && req) begin
        swapped_m = 1'b1;
        pend_m = 1'b0;
      end else begin
        pend_m = req;
      end
      tick();
      check_val("swap_pend", b_pend, pend_m);
      if (b_ov) begin
        expv = -1;
        if (q.size() > 0) expv = q.pop_front();
        check_val("swap_out", b_out, expv);
      end
    end
    s_swap = 1'b0;
    s_wr = 1'b0;
    check_val("swap_left", q.size(), 0);

    // Bypass: centre tap delayed, never saturating
    s_byp = 1'b1;
    s_in = 18'sd1;
    s_en = 1'b1;
    n = 0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (b_ov) begin
        sidx = e - 6;
        expv = (sidx >= 3) ? sidx - 2 : 1;
        check_val("byp_out", b_out, expv);
        check_val("byp_sat", b_sat, 0);
        n++;
      end
      s_in = 18'(e + 1);
      s_en = (e < 12);
    end
    check_val("byp_count", n, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
